// File: rtl/ad_timebase_ctrl.sv
// ad_timebase_ctrl: sequences ADC sample-clock changes.
// Converts single-cycle step requests into the one-hot clock-mux enable.
// Around every switch it holds capture, drains the in-flight frame (bounded
// by a timeout), lets the new clock settle, then re-arms capture.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a live or pending step request
// DRAIN  | capture held, waiting for capture_busy to drop (or timeout)
// SWITCH | one cycle: load new tb_idx / en_out from latched target
// SETTLE | capture held while the new sample clock settles
// REARM  | one cycle: release hold and pulse rearm_pulse
module ad_timebase_ctrl #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int DRAIN_TIMEOUT = 65535,
  parameter int TB_DEFAULT    = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       tb_up,
  input  logic       tb_down,
  input  logic       capture_busy,
  output logic [7:0] en_out,
  output logic [2:0] tb_idx,
  output logic       capture_hold,
  output logic       rearm_pulse,
  output logic       switching,
  output logic       drain_timeout
);

  localparam int MAX_CNT = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  // The shared timer is a down-counter; these are its load values so that
  // reaching zero marks the last cycle of the respective phase.
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       IDX_MAX     = 3'd4;
  localparam logic [2:0]       IDX_RST     = 3'(TB_DEFAULT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE,
    ST_REARM
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       target_q, target_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_inc_q, pend_inc_d;
  logic [2:0]       idx_d;
  logic [7:0]       en_d;
  logic             timeout_d;
  logic             hold_d;
  logic             switching_d;
  logic             rearm_d;

  // Simultaneous up+down cancels; tb_down moves to a larger index.
  logic live_req;
  logic live_inc;
  assign live_req = tb_up ^ tb_down;
  assign live_inc = tb_down;

  function automatic logic [7:0] idx_to_en(input logic [2:0] idx);
    return 8'b0000_0010 << idx;
  endfunction

  function automatic logic at_limit(input logic [2:0] idx, input logic inc);
    return inc ? (idx >= IDX_MAX) : (idx == 3'd0);
  endfunction

  function automatic logic [2:0] step_idx(input logic [2:0] idx, input logic inc);
    return inc ? (idx + 3'd1) : (idx - 3'd1);
  endfunction

  // Next-state, timer, pending-slot and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    pend_valid_d = pend_valid_q;
    pend_inc_d   = pend_inc_q;
    idx_d        = tb_idx;
    en_d         = en_out;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (live_req && !at_limit(tb_idx, live_inc)) begin
          target_d     = step_idx(tb_idx, live_inc);
          pend_valid_d = 1'b0;
          cnt_d        = DRAIN_LAST;
          state_d      = ST_DRAIN;
        end else if (pend_valid_q) begin
          // A pending step that would saturate is discarded here, judged
          // against the index now in force rather than when it arrived.
          pend_valid_d = 1'b0;
          if (!at_limit(tb_idx, pend_inc_q)) begin
            target_d = step_idx(tb_idx, pend_inc_q);
            cnt_d    = DRAIN_LAST;
            state_d  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!capture_busy) begin
          state_d = ST_SWITCH;
        end else if (cnt_q == '0) begin
          timeout_d = 1'b1;
          state_d   = ST_SWITCH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SWITCH: begin
        idx_d   = target_q;
        en_d    = idx_to_en(target_q);
        cnt_d   = SETTLE_LAST;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_REARM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_REARM: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Requests seen while busy go to a single-entry slot, latest wins.
    if ((state_q != ST_IDLE) && live_req) begin
      pend_valid_d = 1'b1;
      pend_inc_d   = live_inc;
    end

    hold_d      = (state_d == ST_DRAIN) || (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
    switching_d = (state_d != ST_IDLE);
    rearm_d     = (state_d == ST_REARM);
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timer, target/pending latches and all outputs, registered.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      target_q      <= IDX_RST;
      pend_valid_q  <= 1'b0;
      pend_inc_q    <= 1'b0;
      tb_idx        <= IDX_RST;
      en_out        <= idx_to_en(IDX_RST);
      capture_hold  <= 1'b0;
      rearm_pulse   <= 1'b0;
      switching     <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      pend_valid_q  <= pend_valid_d;
      pend_inc_q    <= pend_inc_d;
      tb_idx        <= idx_d;
      en_out        <= en_d;
      capture_hold  <= hold_d;
      rearm_pulse   <= rearm_d;
      switching     <= switching_d;
      drain_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ad_timebase_ctrl.sv
// Directed bench for ad_timebase_ctrl: one instance with a 16-cycle settle
// and long drain timeout, a second with a short drain timeout.
module tb_ad_timebase_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       tb_up, tb_down, capture_busy;
  logic [7:0] en_out;
  logic [2:0] tb_idx;
  logic       capture_hold, rearm_pulse, switching, drain_timeout;

  logic       tb_up2, tb_down2, capture_busy2;
  logic [7:0] en_out2;
  logic [2:0] tb_idx2;
  logic       capture_hold2, rearm_pulse2, switching2, drain_timeout2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  ad_timebase_ctrl #(.SETTLE_CYCLES(16), .DRAIN_TIMEOUT(65535), .TB_DEFAULT(4)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .tb_up(tb_up), .tb_down(tb_down),
    .capture_busy(capture_busy), .en_out(en_out), .tb_idx(tb_idx),
    .capture_hold(capture_hold), .rearm_pulse(rearm_pulse),
    .switching(switching), .drain_timeout(drain_timeout)
  );

  ad_timebase_ctrl #(.SETTLE_CYCLES(4), .DRAIN_TIMEOUT(8), .TB_DEFAULT(4)) dut_to (
    .sys_clk(sys_clk), .rst_n(rst_n), .tb_up(tb_up2), .tb_down(tb_down2),
    .capture_busy(capture_busy2), .en_out(en_out2), .tb_idx(tb_idx2),
    .capture_hold(capture_hold2), .rearm_pulse(rearm_pulse2),
    .switching(switching2), .drain_timeout(drain_timeout2)
  );

  function automatic logic [7:0] en_for(input int idx);
    case (idx)
      0: return 8'b0000_0010;
      1: return 8'b0000_0100;
      2: return 8'b0000_1000;
      3: return 8'b0001_0000;
      4: return 8'b0010_0000;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int k, input logic [7:0] e_en,
                          input logic [2:0] e_idx, input logic e_hold,
                          input logic e_rearm, input logic e_sw);
    chk($sformatf("%s_en_k%0d", tag, k), {24'h0, en_out}, {24'h0, e_en});
    chk($sformatf("%s_idx_k%0d", tag, k), {29'h0, tb_idx}, {29'h0, e_idx});
    chk($sformatf("%s_hold_k%0d", tag, k), {31'h0, capture_hold}, {31'h0, e_hold});
    chk($sformatf("%s_rearm_k%0d", tag, k), {31'h0, rearm_pulse}, {31'h0, e_rearm});
    chk($sformatf("%s_sw_k%0d", tag, k), {31'h0, switching}, {31'h0, e_sw});
  endtask

  // Pulse request on the main instance; returns at the first sample point
  // after the capturing edge.
  task automatic pulse(input logic up, input logic dn);
    @(negedge sys_clk);
    tb_up = up; tb_down = dn;
    @(negedge sys_clk);
    tb_up = 1'b0; tb_down = 1'b0;
  endtask

  task automatic wait_rearm(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rearm_pulse) begin
        seen = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    chk(tag, {31'h0, seen}, 32'd1);
    @(negedge sys_clk);
  endtask

  initial begin
    rst_n = 1'b0;
    tb_up = 1'b0; tb_down = 1'b0; capture_busy = 1'b0;
    tb_up2 = 1'b0; tb_down2 = 1'b0; capture_busy2 = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Reset values, during and after reset.
    chk_main("rst_in", 0, 8'b0010_0000, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("rst_in_to", {31'h0, drain_timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);
    chk_main("rst_out", 0, 8'b0010_0000, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("rst_out_to", {31'h0, drain_timeout}, 32'd0);
    chk("rst_out_en2", {24'h0, en_out2}, 32'h20);

    // tb_down at top index saturates: nothing happens.
    pulse(1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      chk_main("sat_hi", k, 8'b0010_0000, 3'd4, 1'b0, 1'b0, 1'b0);
      @(negedge sys_clk);
    end

    // Single tb_up 4->3, idle buffer: exact latency profile.
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      chk_main("single", k, (k >= 3) ? 8'b0001_0000 : 8'b0010_0000,
               (k >= 3) ? 3'd3 : 3'd4, (k >= 1 && k <= 18), (k == 19), (k <= 19));
      @(negedge sys_clk);
    end

    // Drain wait: busy high 40 cycles, switch follows one cycle after release.
    capture_busy = 1'b1;
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      chk_main("drain", k, 8'b0001_0000, 3'd3, 1'b1, 1'b0, 1'b1);
      if (k == 40) capture_busy = 1'b0;
      @(negedge sys_clk);
    end
    chk_main("drain_sw", 41, 8'b0001_0000, 3'd3, 1'b1, 1'b0, 1'b1);
    chk("drain_no_to", {31'h0, drain_timeout}, 32'd0);
    @(negedge sys_clk);
    chk_main("drain_new", 42, 8'b0000_1000, 3'd2, 1'b1, 1'b0, 1'b1);
    wait_rearm("drain_rearm");

    // Drain timeout on the short-timeout instance, busy stuck high.
    capture_busy2 = 1'b1;
    @(negedge sys_clk);
    tb_up2 = 1'b1;
    @(negedge sys_clk);
    tb_up2 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("to_pulse_k%0d", k), {31'h0, drain_timeout2}, {31'h0, (k == 9)});
      chk($sformatf("to_en_k%0d", k), {24'h0, en_out2},
          (k >= 10) ? 32'h10 : 32'h20);
      chk($sformatf("to_rearm_k%0d", k), {31'h0, rearm_pulse2}, {31'h0, (k == 14)});
      chk($sformatf("to_hold_k%0d", k), {31'h0, capture_hold2}, {31'h0, (k <= 13)});
      @(negedge sys_clk);
    end
    capture_busy2 = 1'b0;
    chk("to_idx", {29'h0, tb_idx2}, 32'd3);

    // Walk main instance back to index 4.
    pulse(1'b0, 1'b1);
    wait_rearm("back_rearm_a");
    pulse(1'b0, 1'b1);
    wait_rearm("back_rearm_b");
    chk("back_idx", {29'h0, tb_idx}, 32'd4);

    // Pending: up,up,down during SETTLE -> one extra switch, direction down.
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 45; k++) begin
      chk_main("pend", k, en_for((k < 3) ? 4 : (k < 23) ? 3 : 4),
               (k < 3) ? 3'd4 : (k < 23) ? 3'd3 : 3'd4,
               (k <= 18) || (k >= 21 && k <= 38),
               (k == 19) || (k == 39),
               (k <= 19) || (k >= 21 && k <= 39));
      tb_up   = (k == 5) || (k == 6) || (k == 8);
      tb_down = (k == 7) || (k == 8);
      @(negedge sys_clk);
    end
    tb_up = 1'b0; tb_down = 1'b0;

    // Walk down to 2, then simultaneous up+down in IDLE is ignored.
    pulse(1'b1, 1'b0);
    wait_rearm("walk_rearm_a");
    pulse(1'b1, 1'b0);
    wait_rearm("walk_rearm_b");
    pulse(1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      chk_main("both", k, 8'b0000_1000, 3'd2, 1'b0, 1'b0, 1'b0);
      @(negedge sys_clk);
    end

    // Walk to 0, then tb_up at bottom index saturates.
    pulse(1'b1, 1'b0);
    wait_rearm("walk_rearm_c");
    pulse(1'b1, 1'b0);
    wait_rearm("walk_rearm_d");
    pulse(1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      chk_main("sat_lo", k, 8'b0000_0010, 3'd0, 1'b0, 1'b0, 1'b0);
      @(negedge sys_clk);
    end

    // Mid-operation reset during SETTLE with a pending request queued.
    pulse(1'b0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tb_down = (k == 4);
      @(negedge sys_clk);
    end
    tb_down = 1'b0;
    chk_main("pre_rst", 7, 8'b0000_0100, 3'd1, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("mid_rst", 0, 8'b0010_0000, 3'd4, 1'b0, 1'b0, 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      chk_main("post_rst", k, 8'b0010_0000, 3'd4, 1'b0, 1'b0, 1'b0);
      @(negedge sys_clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
